// File: rtl/rf_pkg.sv
// Shared types and constants for the dual-write-port integer register file
// and its load scoreboard.
package rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int IDW   = 5;
    localparam int CNTW  = $clog2(NREGS + 1);
    localparam int AW    = $clog2(NREGS);

    typedef logic [IDW-1:0]  reg_id_t;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   reg_idx_t;

    // x0 and ids beyond the implemented file never touch state
    function automatic logic id_valid(reg_id_t id);
        return (id != {IDW{1'b0}}) && (int'(id) < NREGS);
    endfunction

    function automatic reg_idx_t id_idx(reg_id_t id);
        return id[AW-1:0];
    endfunction

endpackage

// File: rtl/rf_sb_chk.sv
// Protocol and consistency checks for the register file scoreboard.
module rf_sb_chk
    import rf_pkg::*;
(
    input logic             clock,
    input logic             reset_n,
    input logic             wp0_en,
    input logic [IDW-1:0]   wp0_rd,
    input logic [NREGS-1:0] pending,
    input logic [CNTW-1:0]  pend_cnt
);

    a_wp0_to_pending: assert property (@(posedge clock) disable iff (!reset_n)
        !(wp0_en && id_valid(wp0_rd) && pending[id_idx(wp0_rd)]));

    a_cnt_popcount: assert property (@(posedge clock) disable iff (!reset_n)
        pend_cnt == CNTW'($countones(pending)));

endmodule

// File: rtl/rf_scoreboard.sv
// Outstanding-load scoreboard: pending bits, pending count, WAW issue gate
// and operand stalls that drop in the cycle the load returns.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            iss_valid,
    input  logic [IDW-1:0]  iss_rd,
    input  logic            wp1_en,
    input  logic [IDW-1:0]  wp1_rd,
    input  logic [IDW-1:0]  rs1,
    input  logic [IDW-1:0]  rs2,
    output logic            iss_ready,
    output logic            rs1_stall,
    output logic            rs2_stall,
    output logic [CNTW-1:0] pend_cnt,
    output logic [NREGS-1:0] pending
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic [CNTW-1:0]  pend_cnt_q, pend_cnt_d;
    logic             wp1_ok_s, set_s, set_eff_s, clr_eff_s, iss_ready_s;

    // Issue gate, effective set/clear events and next pending state
    always_comb begin
        wp1_ok_s    = wp1_en && id_valid(wp1_rd);
        iss_ready_s = !id_valid(iss_rd) || !pending_q[id_idx(iss_rd)] ||
                      (wp1_en && (wp1_rd == iss_rd));
        set_s       = iss_valid && iss_ready_s && id_valid(iss_rd);
        // A set on an already-pending bit only happens alongside its own return: net zero
        set_eff_s   = set_s && !pending_q[id_idx(iss_rd)];
        clr_eff_s   = wp1_ok_s && pending_q[id_idx(wp1_rd)] &&
                      !(set_s && (iss_rd == wp1_rd));
        pending_d   = pending_q;
        if (wp1_ok_s) begin
            pending_d[id_idx(wp1_rd)] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (set_s) begin
            pending_d[id_idx(iss_rd)] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pend_cnt_d = pend_cnt_q + CNTW'(set_eff_s) - CNTW'(clr_eff_s);
    end

    // Scoreboard state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= {NREGS{1'b0}};
            pend_cnt_q <= {CNTW{1'b0}};
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Stalls are released by a same-cycle return because the bypass supplies the data
    always_comb begin
        rs1_stall = id_valid(rs1) && pending_q[id_idx(rs1)] && !(wp1_en && (wp1_rd == rs1));
        rs2_stall = id_valid(rs2) && pending_q[id_idx(rs2)] && !(wp1_en && (wp1_rd == rs2));
    end

    assign iss_ready = iss_ready_s;
    assign pend_cnt  = pend_cnt_q;
    assign pending   = pending_q;

endmodule

// File: rtl/rf_sb.sv
// Integer register file with ALU and load-return write ports, write-through
// read bypass and an integrated outstanding-load scoreboard.
module rf_sb
    import rf_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            wp0_en,
    input  logic [IDW-1:0]  wp0_rd,
    input  logic [XLEN-1:0] wp0_data,
    input  logic            wp1_en,
    input  logic [IDW-1:0]  wp1_rd,
    input  logic [XLEN-1:0] wp1_data,
    input  logic [IDW-1:0]  rs1,
    input  logic [IDW-1:0]  rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            rs1_stall,
    output logic            rs2_stall,
    input  logic            iss_valid,
    input  logic [IDW-1:0]  iss_rd,
    output logic            iss_ready,
    output logic [CNTW-1:0] pend_cnt
);

    word_t            regs_q [NREGS];
    word_t            regs_d [NREGS];
    logic             wp0_ok_s, wp1_ok_s;
    logic [NREGS-1:0] pending_s;

    // Write mux: load return overrides the ALU on a shared destination
    always_comb begin
        wp0_ok_s = wp0_en && id_valid(wp0_rd);
        wp1_ok_s = wp1_en && id_valid(wp1_rd);
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = (wp1_ok_s && (id_idx(wp1_rd) == AW'(i))) ? wp1_data :
                        (wp0_ok_s && (id_idx(wp0_rd) == AW'(i))) ? wp0_data :
                        regs_q[i];
        end
    end

    // Register storage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports with write-through bypass, wp1 first
    always_comb begin
        rdata1 = !id_valid(rs1)                  ? {XLEN{1'b0}} :
                 (wp1_en && (wp1_rd == rs1))     ? wp1_data :
                 (wp0_en && (wp0_rd == rs1))     ? wp0_data :
                 regs_q[id_idx(rs1)];
        rdata2 = !id_valid(rs2)                  ? {XLEN{1'b0}} :
                 (wp1_en && (wp1_rd == rs2))     ? wp1_data :
                 (wp0_en && (wp0_rd == rs2))     ? wp0_data :
                 regs_q[id_idx(rs2)];
    end

    rf_scoreboard u_sb (
        .clock     (clock),
        .reset_n   (reset_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wp1_en    (wp1_en),
        .wp1_rd    (wp1_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .iss_ready (iss_ready),
        .rs1_stall (rs1_stall),
        .rs2_stall (rs2_stall),
        .pend_cnt  (pend_cnt),
        .pending   (pending_s)
    );

    rf_sb_chk u_chk (
        .clock    (clock),
        .reset_n  (reset_n),
        .wp0_en   (wp0_en),
        .wp0_rd   (wp0_rd),
        .pending  (pending_s),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_rf_sb.sv
// Directed self-checking bench for rf_sb: reset, collisions, bypass,
// load hazards, WAW gating and out-of-range ids.
module tb_rf_sb;
    import rf_pkg::*;

    logic            clock;
    logic            reset_n;
    logic            wp0_en, wp1_en, iss_valid;
    logic [IDW-1:0]  wp0_rd, wp1_rd, rs1, rs2, iss_rd;
    logic [XLEN-1:0] wp0_data, wp1_data, rdata1, rdata2;
    logic            rs1_stall, rs2_stall, iss_ready;
    logic [CNTW-1:0] pend_cnt;

    int n_checks;
    int n_fails;

    rf_sb dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wp0_en    (wp0_en),
        .wp0_rd    (wp0_rd),
        .wp0_data  (wp0_data),
        .wp1_en    (wp1_en),
        .wp1_rd    (wp1_rd),
        .wp1_data  (wp1_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .rs1_stall (rs1_stall),
        .rs2_stall (rs2_stall),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .pend_cnt  (pend_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wp0_en = 1'b0; wp0_rd = 5'd0; wp0_data = 32'h0;
        wp1_en = 1'b0; wp1_rd = 5'd0; wp1_data = 32'h0;
        iss_valid = 1'b0; iss_rd = 5'd0;
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();
        rs1 = 5'd5; rs2 = 5'd7;
        reset_n = 1'b0;
        #3;
        check_eq("por_rdata1", rdata1, 32'h0);
        check_eq("por_iss_ready", 32'(iss_ready), 32'd1);
        #5 reset_n = 1'b1;
        tick();

        // reset mid-traffic
        wp0_en = 1'b1; wp0_rd = 5'd5; wp0_data = 32'hDEADBEEF;
        tick(); idle();
        #2 check_eq("x5_written", rdata1, 32'hDEADBEEF);
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick(); idle(); iss_rd = 5'd7;
        #2;
        check_eq("x7_pending_cnt", 32'(pend_cnt), 32'd1);
        check_eq("x7_stall", 32'(rs2_stall), 32'd1);
        check_eq("x7_iss_ready", 32'(iss_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check_eq("rst_rdata1", rdata1, 32'h0);
        check_eq("rst_pend_cnt", 32'(pend_cnt), 32'd0);
        check_eq("rst_iss_ready", 32'(iss_ready), 32'd1);
        check_eq("rst_rs2_stall", 32'(rs2_stall), 32'd0);
        #2 reset_n = 1'b1;
        tick();

        // dual-write collision on x3
        wp0_en = 1'b1; wp0_rd = 5'd3; wp0_data = 32'h11;
        wp1_en = 1'b1; wp1_rd = 5'd3; wp1_data = 32'h22;
        rs1 = 5'd3;
        #2 check_eq("coll_bypass", rdata1, 32'h22);
        tick(); idle();
        #2;
        check_eq("coll_stored", rdata1, 32'h22);
        check_eq("coll_cnt_nounderflow", 32'(pend_cnt), 32'd0);

        // bypass and x0
        wp0_en = 1'b1; wp0_rd = 5'd9; wp0_data = 32'hA5A5A5A5; rs1 = 5'd9;
        #2 check_eq("x9_bypass", rdata1, 32'hA5A5A5A5);
        tick(); idle();
        wp0_en = 1'b1; wp0_rd = 5'd0; wp0_data = 32'hFFFFFFFF; rs1 = 5'd0;
        #2 check_eq("x0_bypass", rdata1, 32'h0);
        tick(); idle();
        rs2 = 5'd9;
        #2;
        check_eq("x0_stored", rdata1, 32'h0);
        check_eq("x9_stored", rdata2, 32'hA5A5A5A5);

        // load hazard on x4
        iss_valid = 1'b1; iss_rd = 5'd4;
        #2 check_eq("x4_iss_ready", 32'(iss_ready), 32'd1);
        tick(); idle(); rs2 = 5'd4;
        #2;
        check_eq("x4_stall", 32'(rs2_stall), 32'd1);
        check_eq("x4_cnt", 32'(pend_cnt), 32'd1);
        tick(); tick(); tick();
        wp1_en = 1'b1; wp1_rd = 5'd4; wp1_data = 32'h1234;
        #2;
        check_eq("x4_ret_stall", 32'(rs2_stall), 32'd0);
        check_eq("x4_ret_bypass", rdata2, 32'h1234);
        tick(); idle();
        #2;
        check_eq("x4_ret_cnt", 32'(pend_cnt), 32'd0);
        check_eq("x4_stored", rdata2, 32'h1234);

        // WAW gating and set-wins on x6
        iss_valid = 1'b1; iss_rd = 5'd6;
        tick(); idle();
        iss_valid = 1'b1; iss_rd = 5'd6;
        #2 check_eq("x6_waw_ready", 32'(iss_ready), 32'd0);
        tick(); idle();
        #2 check_eq("x6_waw_cnt", 32'(pend_cnt), 32'd1);
        iss_valid = 1'b1; iss_rd = 5'd6;
        wp1_en = 1'b1; wp1_rd = 5'd6; wp1_data = 32'h66;
        #2 check_eq("x6_reissue_ready", 32'(iss_ready), 32'd1);
        tick(); idle(); rs1 = 5'd6;
        #2;
        check_eq("x6_setwins_stall", 32'(rs1_stall), 32'd1);
        check_eq("x6_setwins_cnt", 32'(pend_cnt), 32'd1);
        check_eq("x6_data", rdata1, 32'h66);
        wp1_en = 1'b1; wp1_rd = 5'd6; wp1_data = 32'h67;
        tick(); idle();
        #2 check_eq("x6_drain_cnt", 32'(pend_cnt), 32'd0);

        // out-of-range id 20 (aliases x4 in the low bits)
        wp0_en = 1'b1; wp0_rd = 5'd20; wp0_data = 32'hCAFE;
        iss_valid = 1'b1; iss_rd = 5'd20; rs1 = 5'd20;
        #2;
        check_eq("oor_iss_ready", 32'(iss_ready), 32'd1);
        check_eq("oor_rdata1", rdata1, 32'h0);
        check_eq("oor_stall", 32'(rs1_stall), 32'd0);
        tick(); idle(); rs1 = 5'd4;
        #2;
        check_eq("oor_cnt", 32'(pend_cnt), 32'd0);
        check_eq("oor_x4_kept", rdata1, 32'h1234);

        // fill every pending bit
        for (int i = 1; i < NREGS; i++) begin
            iss_valid = 1'b1; iss_rd = IDW'(i);
            tick();
        end
        idle();
        iss_valid = 1'b1; iss_rd = 5'd1; rs1 = 5'd15; rs2 = 5'd20;
        #2;
        check_eq("full_cnt", 32'(pend_cnt), 32'd15);
        check_eq("full_ready_x1", 32'(iss_ready), 32'd0);
        check_eq("full_stall_x15", 32'(rs1_stall), 32'd1);
        check_eq("full_stall_oor", 32'(rs2_stall), 32'd0);
        tick(); idle();
        #2 check_eq("full_nowrap", 32'(pend_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
